pipe_ctrl: RTL

Pipeline sequencer for the 5-stage core, owning the EX-stage datapath. Generates per-stage stall/flush, EX operand forwarding selects, and multi-cycle EX op sequencing (M-extension unit) with timeout. Sits beside the stage registers and takes hazard info from ID, EX, MEM and WB. Also keeps a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_fwd_unit.sv | 26 ++
 rtl/pipe_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer: FSM states,
// forwarding selects and the grouped stall/flush bundle.
`ifndef PIPE_CTRL_PKG_SV
`define PIPE_CTRL_PKG_SV

package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic mem_stall;
    logic id_flush;
    logic ex_flush;
    logic mem_flush;
  } pipe_ctrl_out_t;

  // x0 is hardwired to zero, so a write to it never produces a hazard.
  function automatic logic rd_hit(input logic       rf_en,
                                  input logic [4:0] rd,
                                  input logic [4:0] rs);
    return rf_en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

`endif

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; the younger
// MEM-stage result takes precedence over WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  // Select the freshest in-flight producer of rs.
  always_comb begin
    sel = FWD_NONE;
    if (rd_hit(mem_rf_en, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (rd_hit(wb_rf_en, wb_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush generation, EX forwarding selects,
// multi-cycle EX op sequencing with timeout and a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_rf_en,
  input  logic             wb_rf_en,
  input  logic             mem_stall_req,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mc_busy,
  output logic             mc_abort,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TO_W = $clog2(MC_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pc_state_t      state_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic            mc_err_r;

  logic            load_use_s;
  logic            mc_start_s;
  logic            timeout_s;
  logic            mc_hold_s;
  pipe_ctrl_out_t  ctl_s;

  // Hazard and multi-cycle conditions derived from state and current inputs.
  always_comb begin
    load_use_s = ex_is_load &&
                 ((id_rs1_used && rd_hit(ex_rf_en, ex_rd, id_rs1)) ||
                  (id_rs2_used && rd_hit(ex_rf_en, ex_rd, id_rs2)));
    // A taken branch squashes the multi-cycle op, so it must not start.
    mc_start_s = (state_r == RUN) && ex_mc_start && !mc_done && !ex_br_taken;
    timeout_s  = (state_r == MC_BUSY) && !mc_done && (to_cnt_r == TO_LAST);
    mc_hold_s  = ((state_r == MC_BUSY) && !mc_done && !timeout_s) || mc_start_s;
  end

  // Prioritised stall/flush decode; memory back-pressure dominates everything.
  always_comb begin
    ctl_s = 7'b0000000;
    if (mem_stall_req) begin
      ctl_s.if_stall  = 1'b1;
      ctl_s.id_stall  = 1'b1;
      ctl_s.ex_stall  = 1'b1;
      ctl_s.mem_stall = 1'b1;
    end else if (mc_hold_s) begin
      ctl_s.if_stall  = 1'b1;
      ctl_s.id_stall  = 1'b1;
      ctl_s.ex_stall  = 1'b1;
      ctl_s.mem_flush = 1'b1;
    end else if (ex_br_taken) begin
      ctl_s.id_flush  = 1'b1;
      ctl_s.ex_flush  = 1'b1;
    end else if (load_use_s) begin
      ctl_s.if_stall  = 1'b1;
      ctl_s.id_stall  = 1'b1;
      ctl_s.ex_flush  = 1'b1;
    end else begin
      ctl_s = 7'b0000000;
    end
  end

  // Multi-cycle FSM, timeout counter and sticky error; frozen under mem stall.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r  <= RUN;
      to_cnt_r <= '0;
      mc_err_r <= 1'b0;
    end else if (!mem_stall_req) begin
      case (state_r)
        RUN: begin
          if (mc_start_s) begin
            state_r  <= MC_BUSY;
            to_cnt_r <= TO_W'(1);
          end else begin
            state_r  <= RUN;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            state_r  <= RUN;
            to_cnt_r <= '0;
          end else if (timeout_s) begin
            state_r  <= RUN;
            to_cnt_r <= '0;
            mc_err_r <= 1'b1;
          end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end else begin
            to_cnt_r <= to_cnt_r;
          end
        end
        default: begin
          state_r  <= RUN;
          to_cnt_r <= '0;
        end
      endcase
    end else begin
      state_r  <= state_r;
      to_cnt_r <= to_cnt_r;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_r <= '0;
    end else if (ctl_s.if_stall && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  fwd_unit u_fwd_a (
    .rs        (ex_rs1),
    .mem_rd    (mem_rd),
    .mem_rf_en (mem_rf_en),
    .wb_rd     (wb_rd),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .rs        (ex_rs2),
    .mem_rd    (mem_rd),
    .mem_rf_en (mem_rf_en),
    .wb_rd     (wb_rd),
    .wb_rf_en  (wb_rf_en),
    .sel       (fwd_b_sel)
  );

  assign if_stall  = ctl_s.if_stall;
  assign id_stall  = ctl_s.id_stall;
  assign ex_stall  = ctl_s.ex_stall;
  assign mem_stall = ctl_s.mem_stall;
  assign id_flush  = ctl_s.id_flush;
  assign ex_flush  = ctl_s.ex_flush;
  assign mem_flush = ctl_s.mem_flush;
  assign mc_busy   = (state_r == MC_BUSY);
  // Abort coincides with the stall release of the timeout cycle.
  assign mc_abort  = timeout_s && !mem_stall_req;
  assign mc_err    = mc_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule
